// File: rtl/nes_rom_loader.sv
// nes_rom_loader: boot-time iNES image loader. Parses the 16-byte iNES
// header from a byte stream, optionally skips a 512-byte trainer, then writes
// PRG data to SRAM 0x000000.. and CHR data to 0x200000.. through the memory
// controller's write/addr/din/busy handshake, one byte per request.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   in_data/in_valid      stream byte in
//   in_ready              byte consumed when in_valid && in_ready
//   mem_write/mem_addr    one-cycle write request with address and data
//   mem_din/mem_busy      controller data in and busy flag
//   mapper, prg_size, chr_size, mirroring   decoded cartridge configuration
//   done, error           sticky completion / header-rejected flags
//
// Build option: define NES_LOADER_CHR_CLEAR_EN to zero-fill the 8 KB CHR RAM
// window when the image carries no CHR data.
module nes_rom_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_write,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic        mem_busy,
  output logic [7:0]  mapper,
  output logic [7:0]  prg_size,
  output logic [7:0]  chr_size,
  output logic        mirroring,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_HEADER, S_TRAINER, S_PRG, S_CHR, S_CLEAR, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [8:0]  trn_q, trn_d;
  logic [18:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  hold_q, hold_d;
  logic        guard_q, guard_d;
  logic [7:0]  prg_q, prg_d;
  logic [7:0]  chr_q, chr_d;
  logic        mirror_q, mirror_d;
  logic        trainer_q, trainer_d;
  logic [3:0]  maplo_q, maplo_d;
  logic [3:0]  maphi_q, maphi_d;

  logic        accept;
  logic        issue;
  logic        last;
  logic [18:0] region_total;

  // 19-bit totals so that a 16 x 16 KB PRG image (2^18 bytes) does not wrap.
  always_comb begin
    case (state_q)
      S_PRG:   region_total = {prg_q[4:0], 14'd0};
      S_CHR:   region_total = {chr_q[5:0], 13'd0};
      default: region_total = 19'd8192;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign issue  = pend_q && !mem_busy && !guard_q &&
                  ((state_q == S_PRG) || (state_q == S_CHR) || (state_q == S_CLEAR));
  assign last   = ((cnt_q + 19'd1) == region_total);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HEADER;
      idx_q     <= '0;
      trn_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      hold_q    <= '0;
      guard_q   <= 1'b0;
      prg_q     <= '0;
      chr_q     <= '0;
      mirror_q  <= 1'b0;
      trainer_q <= 1'b0;
      maplo_q   <= '0;
      maphi_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      trn_q     <= trn_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      guard_q   <= guard_d;
      prg_q     <= prg_d;
      chr_q     <= chr_d;
      mirror_q  <= mirror_d;
      trainer_q <= trainer_d;
      maplo_q   <= maplo_d;
      maphi_q   <= maphi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    trn_d     = trn_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    prg_d     = prg_q;
    chr_d     = chr_q;
    mirror_d  = mirror_q;
    trainer_d = trainer_q;
    maplo_d   = maplo_q;
    maphi_d   = maphi_q;
    // The controller raises busy one cycle after sampling a write.
    guard_d   = issue;

    case (state_q)
      S_HEADER: begin
        if (accept) begin
          idx_d = idx_q + 4'd1;
          case (idx_q)
            4'd0: if (in_data != 8'h4E) state_d = S_ERROR;
            4'd1: if (in_data != 8'h45) state_d = S_ERROR;
            4'd2: if (in_data != 8'h53) state_d = S_ERROR;
            4'd3: if (in_data != 8'h1A) state_d = S_ERROR;
            4'd4: begin
              prg_d = in_data;
              if ((in_data == 8'd0) || (in_data > 8'd16)) state_d = S_ERROR;
            end
            4'd5: begin
              chr_d = in_data;
              if (in_data > 8'd32) state_d = S_ERROR;
            end
            4'd6: begin
              mirror_d  = in_data[0];
              trainer_d = in_data[2];
              maplo_d   = in_data[7:4];
            end
            4'd7:  maphi_d = in_data[7:4];
            4'd15: begin
              state_d = trainer_q ? S_TRAINER : S_PRG;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end
      S_TRAINER: begin
        if (accept) begin
          trn_d = trn_q + 9'd1;
          if (trn_q == 9'd511) state_d = S_PRG;
        end
      end
      S_PRG, S_CHR, S_CLEAR: begin
        if (issue) begin
          // CLEAR keeps a zero byte permanently pending until its last write.
          pend_d = (state_q == S_CLEAR) && !last;
          cnt_d  = cnt_q + 19'd1;
          if (last) begin
            cnt_d = '0;
            if ((state_q == S_PRG) && (chr_q != 8'd0)) begin
              state_d = S_CHR;
            end else if (state_q == S_PRG) begin
`ifdef NES_LOADER_CHR_CLEAR_EN
              state_d = S_CLEAR;
              pend_d  = 1'b1;
              hold_d  = '0;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_DONE;
            end
          end
        end
        if (accept) begin
          pend_d = 1'b1;
          hold_d = in_data;
        end
      end
      default: pend_d = 1'b0;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    mem_write = issue;
    mem_addr  = '0;
    mem_din   = hold_q;
    case (state_q)
      S_PRG: begin
        // No byte is taken on the region's final write: the next byte
        // belongs to the following region and must see the fresh offset.
        in_ready = !pend_q || (issue && !last);
        mem_addr = {4'b0000, cnt_q[17:0]};
      end
      S_CHR: begin
        in_ready = !pend_q || (issue && !last);
        mem_addr = {4'b1000, cnt_q[17:0]};
      end
      S_CLEAR: begin
        in_ready = 1'b0;
        mem_addr = {4'b1000, cnt_q[17:0]};
      end
      default: ;
    endcase
  end

  assign mapper    = {maphi_q, maplo_q};
  assign prg_size  = prg_q;
  assign chr_size  = chr_q;
  assign mirroring = mirror_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_nes_rom_loader.sv
// Self-checking bench for nes_rom_loader: random image contents, expected
// write list derived from the iNES layout, busy model of the controller.
module tb_nes_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_write;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_busy;
  logic [7:0]  mapper;
  logic [7:0]  prg_size;
  logic [7:0]  chr_size;
  logic        mirroring;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  nes_rom_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_busy(mem_busy), .mapper(mapper),
    .prg_size(prg_size), .chr_size(chr_size), .mirroring(mirroring),
    .done(done), .error(error)
  );

  logic [7:0]   stream [0:65535];
  logic [29:0]  expq [$];
  int unsigned  pos;
  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  cyc = 0;
  bit           busy_en = 1'b0;
  bit           spacing_en = 1'b0;
  int unsigned  writes_seen = 0;
  int unsigned  last_pulse = 0;
  bit           have_pulse = 1'b0;
  bit           prev_pulse = 1'b0;

  // Controller model: samples write at an edge, raises busy one edge later,
  // so a write blocks the next one for three cycles after it is sampled.
  logic        arm_q = 1'b0;
  int unsigned bcnt = 0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    arm_q <= mem_write && busy_en;
    if (arm_q) bcnt <= 2;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign mem_busy = (bcnt != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor
  initial begin
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (mem_write) begin
        if (busy_en) chk("write_while_busy", 32'(mem_busy), 32'd0);
        chk("write_after_pulse", 32'(prev_pulse), 32'd0);
        if (spacing_en && have_pulse) chk("pulse_spacing", 32'(cyc - last_pulse), 32'd4);
        if (expq.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[29:8]));
          chk("wr_data", 32'(mem_din), 32'(e[7:0]));
        end
        writes_seen++;
        last_pulse = cyc;
        have_pulse = 1'b1;
      end
      prev_pulse = mem_write;
    end
  end

  task automatic make_image(input int unsigned prg, input int unsigned chr,
                            input logic [7:0] b6, input logic [7:0] b7);
    for (int i = 0; i < 65536; i++) stream[i] = 8'($urandom);
    stream[0] = 8'h4E; stream[1] = 8'h45; stream[2] = 8'h53; stream[3] = 8'h1A;
    stream[4] = 8'(prg); stream[5] = 8'(chr); stream[6] = b6; stream[7] = b7;
  endtask

  // Expected writes straight from the file layout; cap limits the list
  // for runs that are cut short.
  task automatic build_model(input int unsigned cap);
    int unsigned prg, chr, base, n;
    logic [7:0]  b6;
    expq.delete();
    prg  = 32'(stream[4]);
    chr  = 32'(stream[5]);
    b6   = stream[6];
    base = b6[2] ? 16 + 512 : 16;
    n = 0;
    for (int unsigned i = 0; i < prg * 16384 && n < cap; i++, n++)
      expq.push_back({22'(i), stream[base + i]});
    for (int unsigned i = 0; i < chr * 8192 && n < cap; i++, n++)
      expq.push_back({22'h200000 + 22'(i), stream[base + prg * 16384 + i]});
`ifdef NES_LOADER_CHR_CLEAR_EN
    if (chr == 0)
      for (int unsigned i = 0; i < 8192 && n < cap; i++, n++)
        expq.push_back({22'h200000 + 22'(i), 8'h00});
`endif
  endtask

  // Returns at the falling edge just after the last byte's accepting edge.
  task automatic feed(input int unsigned n, input int unsigned pct);
    int unsigned sent = 0;
    int unsigned t = 0;
    while (sent < n && t < n * 8 + 1000) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) < pct);
      in_data  = stream[pos];
      #4;
      if (in_valid && in_ready) begin
        pos++;
        sent++;
      end
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (sent < n) chk("feed_timeout", sent, n);
  endtask

  task automatic wait_writes(input int unsigned n, input int unsigned budget);
    int unsigned t = 0;
    while (writes_seen < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("write_count", writes_seen, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    pos = 0;
    writes_seen = 0;
    have_pulse = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_mapper", 32'(mapper), 32'd0);
    chk("rst_prg_size", 32'(prg_size), 32'd0);
    chk("rst_chr_size", 32'(chr_size), 32'd0);
    chk("rst_mirroring", 32'(mirroring), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0]  b6, b7;
    int unsigned chr, t, p;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; pos = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;

    // Bad magic: fourth byte wrong
    do_reset();
    make_image(1, 1, 8'h00, 8'h00);
    stream[3] = 8'($urandom_range(0, 25));
    feed(3, 100);
    chk("magic_err_early", 32'(error), 32'd0);
    feed(1, 100);
    chk("magic_err", 32'(error), 32'd1);
    feed(20, 100);
    chk("magic_err_sticky", 32'(error), 32'd1);
    chk("magic_no_writes", writes_seen, 32'd0);
    chk("magic_done", 32'(done), 32'd0);

    // PRG size 17 rejected at byte 4
    do_reset();
    make_image(17, 1, 8'h00, 8'h00);
    feed(4, 100);
    chk("prg17_err_early", 32'(error), 32'd0);
    feed(1, 100);
    chk("prg17_err", 32'(error), 32'd1);
    chk("prg17_size", 32'(prg_size), 32'd17);

    // CHR size 33 rejected at byte 5
    do_reset();
    make_image($urandom_range(1, 16), 33, 8'h00, 8'h00);
    feed(5, 100);
    chk("chr33_err_early", 32'(error), 32'd0);
    feed(1, 100);
    chk("chr33_err", 32'(error), 32'd1);
    chk("chr33_size", 32'(chr_size), 32'd33);

    // PRG size 16 is the largest accepted
    do_reset();
    make_image(16, $urandom_range(0, 32), 8'h00, 8'h00);
    build_model(64);
    feed(16 + 64, $urandom_range(50, 100));
    wait_writes(64, 2000);
    chk("prg16_no_err", 32'(error), 32'd0);
    chk("prg16_size", 32'(prg_size), 32'd16);

    // Trainer skip with busy model and continuous input: pulses 4 apart
    do_reset();
    b6 = {4'($urandom), 1'b0, 1'b1, 1'b0, 1'($urandom)};
    b7 = 8'($urandom);
    make_image(2, 0, b6, b7);
    build_model(200);
    busy_en = 1'b1;
    spacing_en = 1'b1;
    feed(16 + 512 + 200, 100);
    wait_writes(200, 2000);
    spacing_en = 1'b0;
    chk("trn_mapper", 32'(mapper), 32'({b7[7:4], b6[7:4]}));
    chk("trn_mirroring", 32'(mirroring), 32'(b6[0]));
    chk("trn_no_err", 32'(error), 32'd0);

    // Reset at PRG byte 100, then a full reload from the header
    do_reset();
    make_image(1, 1, 8'h01, 8'h00);
    build_model(100);
    busy_en = 1'($urandom);
    feed(16 + 100, 100);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    expq.delete();
    pos = 0;
    writes_seen = 0;
    have_pulse = 1'b0;

`ifdef NES_LOADER_CHR_CLEAR_EN
    chr = 0;
`else
    chr = 1;
`endif
    busy_en = 1'b0;
    make_image(1, chr, 8'h01, 8'h00);
    build_model(32'hFFFF_FFFF);
    p = expq.size();
    feed(16 + 16384 + chr * 8192, 100);
    t = 0;
    while (!done && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk("img_done", 32'(done), 32'd1);
    chk("img_done_latency", 32'(cyc - last_pulse), 32'd1);
    chk("img_all_writes", writes_seen, p);
    chk("img_queue_empty", 32'(expq.size()), 32'd0);
    chk("img_mirroring", 32'(mirroring), 32'd1);
    chk("img_mapper", 32'(mapper), 32'd0);
    chk("img_prg_size", 32'(prg_size), 32'd1);
    chk("img_chr_size", 32'(chr_size), chr);
    chk("img_error", 32'(error), 32'd0);
    p = writes_seen;
    stream[pos] = 8'h5A;
    feed(8, 100);
    chk("img_drain_no_writes", writes_seen, p);
    chk("img_done_sticky", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
